// File: rtl/case_1_sdiv_16s_8s_10_seq.sv
// Multi-cycle signed divider: 16-bit signed dividend / 8-bit signed divisor,
// one radix-2 non-restoring step per enabled cycle, fixed 17-cycle latency.
// Ports:
//   ap_clk, ap_rst  clock, asynchronous active-high reset
//   ce              clock enable; low freezes all state and outputs
//   start           request, operands din0/din1 sampled on the accepting edge
//   busy            high while iterating
//   done            one-cycle result strobe (stretched while ce is low)
//   dout            low dout_WIDTH bits of the truncated quotient
//   rem             remainder, sign of the dividend
//   div_zero        result was produced with a zero divisor
module case_1_sdiv_16s_8s_10_seq #(
  parameter int unsigned din0_WIDTH = 16,
  parameter int unsigned din1_WIDTH = 8,
  parameter int unsigned dout_WIDTH = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero
);

  // Partial remainder: divisor magnitude bits plus one guard bit plus sign.
  localparam int unsigned PR_W  = din1_WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(din0_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(din0_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [din0_WIDTH-1:0] acc, acc_nxt;       // dividend bits out, quotient bits in
  logic [din1_WIDTH-1:0] dvs, dvs_nxt;       // divisor magnitude
  logic [PR_W-1:0]       pr, pr_nxt;         // signed partial remainder
  logic                  neg_rem, neg_rem_nxt;
  logic                  neg_quot, neg_quot_nxt;
  logic                  dz, dz_nxt;
  logic                  busy_nxt, done_nxt, div_zero_nxt;
  logic [dout_WIDTH-1:0] dout_nxt;
  logic [din1_WIDTH-1:0] rem_nxt;

  logic [PR_W-1:0]       dvs_ext, pr_shl, pr_step, pr_fix;
  logic [din0_WIDTH-1:0] q_mag, q_full;
  logic [din1_WIDTH-1:0] rem_mag, rem_full;

  // One non-restoring step plus the final correction and sign application.
  always_comb begin
    dvs_ext  = PR_W'(dvs);
    pr_shl   = {pr[PR_W-2:0], acc[din0_WIDTH-1]};
    pr_step  = pr[PR_W-1] ? (pr_shl + dvs_ext) : (pr_shl - dvs_ext);
    q_mag    = {acc[din0_WIDTH-2:0], ~pr_step[PR_W-1]};
    pr_fix   = pr_step[PR_W-1] ? (pr_step + dvs_ext) : pr_step;
    q_full   = neg_quot ? (-q_mag) : q_mag;
    rem_mag  = pr_fix[din1_WIDTH-1:0];
    rem_full = neg_rem ? (-rem_mag) : rem_mag;
  end

  // Next-state and register updates.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    dvs_nxt      = dvs;
    pr_nxt       = pr;
    neg_rem_nxt  = neg_rem;
    neg_quot_nxt = neg_quot;
    dz_nxt       = dz;
    busy_nxt     = busy;
    done_nxt     = done;
    dout_nxt     = dout;
    rem_nxt      = rem;
    div_zero_nxt = div_zero;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (start) begin
          state_nxt    = CALC;
          busy_nxt     = 1'b1;
          cnt_nxt      = '0;
          pr_nxt       = '0;
          acc_nxt      = din0[din0_WIDTH-1] ? (-din0) : din0;
          dvs_nxt      = din1[din1_WIDTH-1] ? (-din1) : din1;
          neg_rem_nxt  = din0[din0_WIDTH-1];
          neg_quot_nxt = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
          dz_nxt       = (din1 == '0);
        end
      end
      CALC: begin
        cnt_nxt = cnt + CNT_W'(1);
        pr_nxt  = pr_step;
        acc_nxt = q_mag;
        if (cnt == LAST_STEP) begin
          state_nxt    = DONE;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          dout_nxt     = dz ? '1 : q_full[dout_WIDTH-1:0];
          rem_nxt      = dz ? '0 : rem_full;
          div_zero_nxt = dz;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // State register; ce low holds everything, including a pending done.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      dvs      <= '0;
      pr       <= '0;
      neg_rem  <= 1'b0;
      neg_quot <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else if (ce) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      dvs      <= dvs_nxt;
      pr       <= pr_nxt;
      neg_rem  <= neg_rem_nxt;
      neg_quot <= neg_quot_nxt;
      dz       <= dz_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      dout     <= dout_nxt;
      rem      <= rem_nxt;
      div_zero <= div_zero_nxt;
    end
  end

endmodule

// File: doc/case_1_sdiv_16s_8s_10_seq.md
# case_1_sdiv_16s_8s_10_seq

Multi-cycle signed integer divider for the case_1 datapath: the inverse operator of the combinational signed multiplier cores. Divides a 16-bit signed dividend by an 8-bit signed divisor and returns a truncated 10-bit signed quotient and an 8-bit signed remainder. It uses one radix-2 non-restoring step per cycle, behind a start/done handshake with a clock-enable, so the scheduler can treat it as a fixed-latency operator.

## Interface
- din0_WIDTH, 16: dividend width, signed.
- din1_WIDTH, 8: divisor width, signed.
- dout_WIDTH, 10: quotient output width; low bits of the full 16-bit quotient.
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ce  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  request; operands sampled on the same edge.
- din0  in  din0_WIDTH  dividend.
- din1  in  din1_WIDTH  divisor.
- busy  out  1  high in CALC.
- done  out  1  one-cycle pulse; results valid from this cycle.
- dout  out  dout_WIDTH  quotient, truncated toward zero, low dout_WIDTH bits.
- rem  out  din1_WIDTH  remainder; carries the sign of the dividend.
- div_zero  out  1  divisor was zero for the result being presented.

## Operation
- States: IDLE, CALC, DONE.
- **Start acceptance:** start is accepted when ce=1 and the state is IDLE or DONE (back-to-back allowed). It is ignored in CALC.
- **On accept:**
  - Latch the dividend and divisor magnitudes, the dividend sign and the quotient sign (sign0 XOR sign1).
  - Clear the partial remainder and the step counter.
  - Go to CALC.
- **CALC:**
  - One shift/subtract step per enabled cycle on the unsigned 16-bit magnitude by 8-bit magnitude.
  - Partial remainder is 9 bits plus sign.
  - After step 16, do the final remainder correction, apply the signs, register the outputs and go to DONE.
- **DONE:** done=1 for one enabled cycle, then go to IDLE unless a new start is accepted.
- **Output hold:** dout, rem and div_zero hold their last values until the next result is registered.
- **Sign rules:**
  - Quotient = trunc(din0/din1).
  - rem = din0 - quotient*din1, with |rem| < |din1|, and rem is 0 or has the sign of din0.
  - The full quotient is 16 bits; dout is its low dout_WIDTH bits. Wrap without saturation.
- **Divide by zero (din1=0):**
  - Full quotient = 0xFFFF, so dout = all ones.
  - rem = 0, div_zero = 1.
  - Latency is unchanged.
- **Overflow:** -32768 / -1 gives full quotient 0x8000, so dout = 0x000, rem = 0, div_zero = 0.
- **Divisor -128:** handled via the 8-bit magnitude 128, which uses the 9-bit partial remainder.
- **ce=0 in any state:**
  - State, counter, outputs and the done level are frozen.
  - A done pulse stretches for as long as ce is low.
- **Reset (asserted at any time, including mid-CALC):**
  - Immediately: state=IDLE, busy=0, done=0, dout=0, rem=0, div_zero=0, counter=0.
  - Any in-flight operation is discarded.

## Timing
- Start accepted on edge E0 (ce=1). busy=1 from after E0 through the CALC cycles.
- With ce held high, done=1 in the cycle after edge E0+16, i.e. 17 cycles after the accepting edge. busy drops in the same cycle.
- Throughput is one result per 17 cycles with back-to-back starts: a start during the done cycle is accepted on that edge.
- Each cycle with ce=0 adds exactly one cycle of latency.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Basic signs** (ce=1, one start each):
  - 1000/7 → dout=142 (0x08E), rem=6.
  - -1000/7 → dout=-142 (0x372), rem=-6 (0xFA).
  - 1000/-7 → dout=0x372, rem=6.
  - In every case done appears exactly 17 cycles after the start edge.
- **Truncation and overflow:**
  - 5000/3 → full quotient 1666 (0x682), dout=0x282, rem=2.
  - -32768/-1 → dout=0x000, rem=0, div_zero=0.
  - 127/-128 → dout=0, rem=127.
- **Divide by zero:** 1234/0 → dout=0x3FF, rem=0, div_zero=1 at cycle 17. A following 10/5 → dout=2, rem=0, div_zero=0.
- **Back-to-back:**
  - Starts at the accepting edge and again in the done cycle, with 100/10 then -100/9.
  - Required: done pulses 17 cycles apart with dout=10 then dout=-11 (0x3F5), rem=-1.
  - Starts asserted during CALC are ignored.
- **Clock enable:** 100/10 with ce=0 for 5 cycles mid-CALC → done at cycle 22; outputs and state frozen during the gap. ce=0 during done → pulse stretched.
- **Reset mid-operation:**
  - Assert ap_rst asynchronously (between clock edges) at CALC step 8.
  - Required: all outputs are 0 before the next edge, and no done pulse follows.
  - After release, 81/9 → dout=9, rem=0 at cycle 17.
